// File: rtl/aes_sub_bytes_seq_pkg.sv
// rtl/aes_sub_bytes_seq_pkg.sv - shared types and helpers for the AES SubBytes stage
// Purpose: state geometry constants, the byte-array state type, the SubBytes
//          FSM encoding and a ShiftRows helper reused by neighbouring stages.
// Ports:   none (package).
package aes_sub_bytes_seq_pkg;

  localparam int BYTE      = 8;
  localparam int STATE_W   = 128;
  localparam int NUM_BYTES = 16;

  typedef logic [BYTE-1:0] aes_state_t [NUM_BYTES];

  typedef enum logic [1:0] {SB_IDLE, SB_SUB, SB_DONE} sub_bytes_fsm_t;

  // Byte k = 4c+r sits at s[STATE_W-1-8k -: 8]; row r rotates left by r columns,
  // so output s'[r,c] = s[r,(c+r) mod 4].
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[STATE_W-1-BYTE*(4*c+row) -: BYTE] =
          s[STATE_W-1-BYTE*(4*((c+row)%4)+row) -: BYTE];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_bytes_seq_sbox.sv
// rtl/aes_sub_bytes_seq_sbox.sv - combinational AES forward S-box
// Purpose: one byte substitution through the FIPS-197 S-box table.
// Ports:   in_byte  [7:0] input  byte to substitute
//          out_byte [7:0] output substituted byte
module aes_sub_bytes_seq_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX_TABLE[in_byte];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// rtl/aes_sub_bytes_seq.sv - iterative AES SubBytes stage, NUM_SBOX bytes per cycle
// Purpose: accepts one 128-bit state, substitutes its 16 bytes through NUM_SBOX
//          shared S-boxes over 16/NUM_SBOX cycles, returns the result on a
//          valid/ready handshake. Build macro AES_SHIFTROWS_EN additionally
//          applies ShiftRows on the output wiring (no extra cycles).
// Ports:   clk, rst (sync active-high)
//          in_valid/in_ready/in_state[127:0]     input state handshake
//          out_valid/out_ready/out_state[127:0]  result handshake
//          busy                                  high while in SUB or DONE
module aes_sub_bytes_seq
  import aes_sub_bytes_seq_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int STEPS = NUM_BYTES / NUM_SBOX;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SH    = $clog2(NUM_SBOX);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  generate
    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
          NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
      $error("aes_sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sub_bytes_fsm_t   fsm;
  logic [CNT_W-1:0] cnt;
  aes_state_t       state_q;
  logic [3:0]       base;
  logic [3:0]       idx [NUM_SBOX];
  logic [BYTE-1:0]  sub [NUM_SBOX];
  logic [STATE_W-1:0] flat;

  // First byte handled this step; the shift always stays within 4 bits.
  assign base = 4'(cnt) << SH;

  generate
    for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
      assign idx[i] = base + 4'(i);
      aes_sub_bytes_seq_sbox u_sbox (
        .in_byte  (state_q[idx[i]]),
        .out_byte (sub[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= SB_IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int b = 0; b < NUM_BYTES; b++) state_q[b] <= '0;
    end else begin
      case (fsm)
        SB_IDLE: begin
          if (in_valid) begin
            for (int b = 0; b < NUM_BYTES; b++)
              state_q[b] <= in_state[STATE_W-1-BYTE*b -: BYTE];
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= SB_SUB;
          end
        end
        SB_SUB: begin
          for (int i = 0; i < NUM_SBOX; i++) state_q[idx[i]] <= sub[i];
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            fsm       <= SB_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SB_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= SB_IDLE;
          end
        end
        default: begin
          fsm       <= SB_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // The state register is the result; partially substituted bytes are only
  // exposed while out_valid is low.
  always_comb begin
    flat = '0;
    for (int b = 0; b < NUM_BYTES; b++) flat[STATE_W-1-BYTE*b -: BYTE] = state_q[b];
  end

`ifdef AES_SHIFTROWS_EN
  assign out_state = shift_rows(flat);
`else
  assign out_state = flat;
`endif

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb/tb_aes_sub_bytes_seq.sv - directed self-checking bench for aes_sub_bytes_seq
module tb_aes_sub_bytes_seq;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp_sb;
    logic [127:0] exp_sr;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] in_state = '0;
  logic         iv  [3];
  logic         orr [3];
  logic         ir  [3];
  logic         ov  [3];
  logic         bsy [3];
  logic [127:0] os  [3];

  int tests = 0;
  int fails = 0;
  vec_t vecs [5];
  int   lat  [3];

  always #5 clk = ~clk;

  aes_sub_bytes_seq #(.NUM_SBOX(4)) u_n4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_state(os[0]), .busy(bsy[0]));
  aes_sub_bytes_seq #(.NUM_SBOX(1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_state(os[1]), .busy(bsy[1]));
  aes_sub_bytes_seq #(.NUM_SBOX(16)) u_n16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_state(os[2]), .busy(bsy[2]));

  function automatic logic [127:0] exp_of(input vec_t v);
`ifdef AES_SHIFTROWS_EN
    return v.exp_sr;
`else
    return v.exp_sb;
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One transaction on DUT d, checking latency from handshake and the result.
  task automatic run_one(input int d, input logic [127:0] din, input logic [127:0] exp,
                         input string nm);
    int n;
    @(negedge clk);
    n = 0;
    while (!ir[d] && n < 50) begin @(negedge clk); n++; end
    chk({nm, " in_ready"}, 128'(ir[d]), 128'd1);
    in_state = din;
    iv[d] = 1'b1;
    @(negedge clk);
    iv[d] = 1'b0;
    n = 1;
    while (!ov[d] && n < 60) begin @(negedge clk); n++; end
    chk({nm, " latency"}, 128'(n), 128'(lat[d]));
    chk({nm, " data"}, os[d], exp);
    orr[d] = 1'b1;
    @(negedge clk);
    orr[d] = 1'b0;
    chk({nm, " out_valid drop"}, 128'(ov[d]), 128'd0);
  endtask

  initial begin
    vecs[0] = '{128'h00112233445566778899aabbccddeeff,
                128'h638293c31bfc33f5c4eeacea4bc12816,
                128'h63fcac161bee28c3c4c193f54b8233ea};
    vecs[1] = '{128'h0, {16{8'h63}}, {16{8'h63}}};
    vecs[2] = '{{16{8'hff}}, {16{8'h16}}, {16{8'h16}}};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h637c777bf26b6fc53001672bfed7ab76,
                128'h636b6776f201ab7b30d777c5fe7c6f2b};
    vecs[4] = '{128'h101112131415161718191a1b1c1d1e1f,
                128'hca82c97dfa5947f0add4a2af9ca472c0,
                128'hca59a2c0fad4727dada4c9f09c8247af};
    lat[0] = 5; lat[1] = 17; lat[2] = 2;
    for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; orr[d] = 1'b0; end

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready",  128'(ir[0]),  128'd1);
    chk("reset out_valid", 128'(ov[0]),  128'd0);
    chk("reset busy",      128'(bsy[0]), 128'd0);
    chk("reset out_state", os[0], 128'h0);

    // Table-driven vectors on NUM_SBOX=4
    for (int k = 0; k < 5; k++)
      run_one(0, vecs[k].din, exp_of(vecs[k]), $sformatf("vec%0d", k));

    // Backpressure: hold out_ready low 10 cycles, ignored in_valid pulse
    begin
      int n;
      @(negedge clk);
      in_state = vecs[1].din;
      iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      n = 1;
      while (!ov[0] && n < 60) begin @(negedge clk); n++; end
      chk("bp latency", 128'(n), 128'd5);
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("bp out_valid c%0d", c), 128'(ov[0]), 128'd1);
        chk($sformatf("bp out_state c%0d", c), os[0], exp_of(vecs[1]));
        chk($sformatf("bp in_ready c%0d", c), 128'(ir[0]), 128'd0);
        if (c == 3) begin in_state = vecs[0].din; iv[0] = 1'b1; end
        else iv[0] = 1'b0;
        @(negedge clk);
      end
      iv[0] = 1'b0;
      orr[0] = 1'b1;
      @(negedge clk);
      orr[0] = 1'b0;
      chk("bp release out_valid", 128'(ov[0]), 128'd0);
      chk("bp release in_ready", 128'(ir[0]), 128'd1);
      chk("bp hold out_state", os[0], exp_of(vecs[1]));
    end

    // Reset in cycle 2 of SUB, then a clean transaction
    @(negedge clk);
    in_state = vecs[0].din;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready",  128'(ir[0]),  128'd1);
    chk("midrst out_valid", 128'(ov[0]),  128'd0);
    chk("midrst busy",      128'(bsy[0]), 128'd0);
    chk("midrst out_state", os[0], 128'h0);
    run_one(0, vecs[0].din, exp_of(vecs[0]), "post-rst");

    // Back-to-back with out_ready tied high
    begin
      int k, j, last, cyc;
      k = 0; j = 0; last = 0;
      orr[0] = 1'b1;
      for (cyc = 0; cyc < 80 && j < 3; cyc++) begin
        @(negedge clk);
        if (ov[0]) begin
          chk($sformatf("b2b data%0d", j), os[0], exp_of(vecs[j + 2]));
          if (j > 0) chk($sformatf("b2b gap%0d", j), 128'(cyc - last), 128'd6);
          last = cyc;
          j++;
        end
        if (ir[0]) begin
          if (k < 3) begin in_state = vecs[k + 2].din; iv[0] = 1'b1; k++; end
          else iv[0] = 1'b0;
        end
      end
      iv[0] = 1'b0;
      orr[0] = 1'b0;
      chk("b2b count", 128'(j), 128'd3);
    end

    // NUM_SBOX sweep
    run_one(1, vecs[0].din, exp_of(vecs[0]), "n1");
    run_one(2, vecs[0].din, exp_of(vecs[0]), "n16");
    run_one(2, vecs[3].din, exp_of(vecs[3]), "n16 vec3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
